// File: rtl/apb_mem_if.sv
// APB4 completer-side bus bundle for apb_mem_slave, including the decoder's
// strobe/address error flag that travels alongside each transfer.
interface apb_mem_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic        strb_addr_error;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pstrb, pwdata, strb_addr_error,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pstrb, pwdata, strb_addr_error,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 byte-addressed memory completer with strobed 32-bit transfers and error reporting.
// Optional macro APB_MEM_WAIT_EN compiles in the WaitStates pready back-pressure counter.
module apb_mem_slave #(
  parameter int unsigned NumWords   = 64,
  parameter int unsigned WaitStates = 0
) (
  input logic      clk,
  input logic      rst,
  apb_mem_if.slave apb_s
);
  localparam int unsigned AW = $clog2(NumWords);

  if (NumWords < 4 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_size
    $error("apb_mem_slave: NumWords must be a power of two >= 4");
  end
  if (WaitStates > 15) begin : g_bad_wait
    $error("apb_mem_slave: WaitStates must be 0..15");
  end

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      strb_q, strb_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [31:0]     prdata_q, prdata_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [7:0]      mem_q [NumWords];
`ifdef APB_MEM_WAIT_EN
  logic [3:0]      cnt_q, cnt_d;
`endif

  logic            setup_c;
  logic            err_in_c;
  logic            commit_c;
  logic            raise_setup_c;
  logic [AW-1:0]   src_addr_c;
  logic            src_kill_c;
  logic [31:0]     rd_c;
  logic [AW:0]     sum_c;

  assign setup_c  = (state_q == IDLE) && apb_s.psel && !apb_s.penable;
  assign err_in_c = (|apb_s.paddr[31:AW]) || (apb_s.pwrite && apb_s.strb_addr_error);

`ifdef APB_MEM_WAIT_EN
  assign raise_setup_c = (WaitStates == 0);
`else
  assign raise_setup_c = 1'b1;
`endif

  // Read data comes from the live bus at SETUP, otherwise from the captured address.
  always_comb begin : read_path
    src_addr_c = (state_q == IDLE) ? apb_s.paddr[AW-1:0] : addr_q;
    src_kill_c = (state_q == IDLE) ? (apb_s.pwrite || err_in_c) : (write_q || err_q);
    rd_c       = '0;
    sum_c      = '0;
    for (int i = 0; i < 4; i++) begin
      sum_c = {1'b0, src_addr_c} + (AW+1)'(i);
      if (!sum_c[AW]) rd_c[8*i +: 8] = mem_q[sum_c[AW-1:0]];
    end
    if (src_kill_c) rd_c = '0;
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_MEM_WAIT_EN
      cnt_q     <= '0;
`endif
      for (int k = 0; k < NumWords; k++) mem_q[k] <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_MEM_WAIT_EN
      cnt_q     <= cnt_d;
`endif
      if (commit_c) begin
        for (int i = 0; i < 4; i++) begin
          if (strb_q[i]) mem_q[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup_c) state_d = ACCESS;
      ACCESS: begin
        if (!apb_s.psel)                      state_d = IDLE;
        else if (apb_s.penable && pready_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    addr_d    = addr_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    commit_c  = 1'b0;
`ifdef APB_MEM_WAIT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (setup_c) begin
          addr_d  = apb_s.paddr[AW-1:0];
          strb_d  = apb_s.pstrb;
          wdata_d = apb_s.pwdata;
          write_d = apb_s.pwrite;
          err_d   = err_in_c;
`ifdef APB_MEM_WAIT_EN
          cnt_d   = '0;
`endif
          if (raise_setup_c) begin
            pready_d  = 1'b1;
            pslverr_d = err_in_c;
            prdata_d  = rd_c;
          end
        end
      end
      ACCESS: begin
        if (!apb_s.psel) begin
          // Protocol violation: drop the transfer without touching memory.
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (pready_q) begin
          if (apb_s.penable) begin
            commit_c  = write_q && !err_q;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end
        end else begin
`ifdef APB_MEM_WAIT_EN
          cnt_d = cnt_q + 4'd1;
          if ((5'(cnt_q) + 5'd1) == 5'(WaitStates)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = rd_c;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  assign apb_s.prdata  = prdata_q;
  assign apb_s.pready  = pready_q;
  assign apb_s.pslverr = pslverr_q;
endmodule
